// File: rtl/muldiv_iter_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: ALU operation codes,
// FSM state encodings visible to the hazard logic, and operation decode helpers.
package muldiv_iter_unit_pkg;

    localparam logic [4:0] ALU_ADD           = 5'd2;
    localparam logic [4:0] ALU_SIGNED_MULT   = 5'd16;
    localparam logic [4:0] ALU_UNSIGNED_MULT = 5'd17;
    localparam logic [4:0] ALU_SIGNED_DIV    = 5'd18;
    localparam logic [4:0] ALU_UNSIGNED_DIV  = 5'd19;

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_CALC = 2'd1;
    localparam logic [1:0] MD_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = MD_IDLE,
        ST_CALC = MD_CALC,
        ST_DONE = MD_DONE
    } md_state_e;

    typedef struct packed {
        logic is_div;
        logic is_signed;
    } md_kind_t;

    function automatic logic is_md_op(input logic [4:0] code);
        case (code)
            ALU_SIGNED_MULT,
            ALU_UNSIGNED_MULT,
            ALU_SIGNED_DIV,
            ALU_UNSIGNED_DIV: is_md_op = 1'b1;
            default:          is_md_op = 1'b0;
        endcase
    endfunction

    function automatic md_kind_t decode_kind(input logic [4:0] code);
        md_kind_t k;
        k.is_div    = (code == ALU_SIGNED_DIV)  || (code == ALU_UNSIGNED_DIV);
        k.is_signed = (code == ALU_SIGNED_MULT) || (code == ALU_SIGNED_DIV);
        return k;
    endfunction

endpackage

// File: rtl/muldiv_iter_unit_step.sv
// One iteration of the shared datapath: a shift-add multiply step or a
// restoring-divide step over unsigned magnitudes.
module muldiv_step #(
    parameter int DATA_W = 32
) (
    input  logic              is_div,
    input  logic [DATA_W:0]   work_hi,
    input  logic [DATA_W-1:0] work_lo,
    input  logic [DATA_W-1:0] m,
    output logic [DATA_W:0]   next_hi,
    output logic [DATA_W-1:0] next_lo
);

    logic [DATA_W:0] sum_s;
    logic [DATA_W:0] shifted_s;
    logic [DATA_W:0] diff_s;

    // Multiply shifts {hi,lo} right after a conditional add; divide shifts left and trial-subtracts.
    always_comb begin
        sum_s     = work_hi + (work_lo[0] ? {1'b0, m} : {(DATA_W+1){1'b0}});
        shifted_s = {work_hi[DATA_W-1:0], work_lo[DATA_W-1]};
        diff_s    = shifted_s - {1'b0, m};
        if (is_div) begin
            // A clear top bit means the trial subtraction did not borrow.
            if (!diff_s[DATA_W]) begin
                next_hi = diff_s;
                next_lo = {work_lo[DATA_W-2:0], 1'b1};
            end else begin
                next_hi = shifted_s;
                next_lo = {work_lo[DATA_W-2:0], 1'b0};
            end
        end else begin
            next_hi = {1'b0, sum_s[DATA_W:1]};
            next_lo = {sum_s[0], work_lo[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative multiply/divide engine: latches magnitudes at start, runs DATA_W
// iterations, then applies sign correction and presents {hi, lo} with a done pulse.
module muldiv_iter_unit
    import muldiv_iter_unit_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [4:0]        alu_control,
    input  logic              op_valid,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    output logic              ready,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              div_by_zero
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    md_state_e         state_r;
    md_state_e         state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              is_div_r;
    logic              is_signed_r;
    logic              sa_r;
    logic              sb_r;
    logic              dz_r;
    logic [DATA_W-1:0] raw_a_r;
    logic [DATA_W-1:0] m_r;
    logic [DATA_W:0]   work_hi_r;
    logic [DATA_W-1:0] work_lo_r;
    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;
    logic              done_r;
    logic              dz_out_r;

    md_kind_t          kind_s;
    logic              is_md_s;
    logic              start_s;
    logic              last_s;
    logic              finish_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [DATA_W-1:0] abs_a_s;
    logic [DATA_W-1:0] abs_b_s;
    logic [DATA_W:0]   step_hi_s;
    logic [DATA_W-1:0] step_lo_s;
    logic [2*DATA_W-1:0] prod_raw_s;
    logic [2*DATA_W-1:0] prod_s;
    logic [DATA_W-1:0] res_hi_s;
    logic [DATA_W-1:0] res_lo_s;

    function automatic logic [DATA_W-1:0] cond_negate(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    muldiv_step #(.DATA_W(DATA_W)) u_step (
        .is_div  (is_div_r),
        .work_hi (work_hi_r),
        .work_lo (work_lo_r),
        .m       (m_r),
        .next_hi (step_hi_s),
        .next_lo (step_lo_s)
    );

    // Operation decode, start/finish qualifiers and operand magnitudes.
    always_comb begin
        is_md_s  = is_md_op(alu_control);
        kind_s   = decode_kind(alu_control);
        start_s  = (state_r == ST_IDLE) && op_valid && is_md_s && !flush;
        last_s   = (state_r == ST_CALC) && (cnt_r == CNT_LAST);
        finish_s = last_s && !flush;
        a_neg_s  = kind_s.is_signed && src_a[DATA_W-1];
        b_neg_s  = kind_s.is_signed && src_b[DATA_W-1];
        abs_a_s  = cond_negate(src_a, a_neg_s);
        abs_b_s  = cond_negate(src_b, b_neg_s);
    end

    // Next-state logic; a flush always returns to IDLE without completing.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_CALC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Final result from the last iteration with sign correction and divide-by-zero override.
    always_comb begin
        prod_raw_s = {step_hi_s[DATA_W-1:0], step_lo_s};
        prod_s     = (is_signed_r && (sa_r ^ sb_r)) ? -prod_raw_s : prod_raw_s;
        if (is_div_r && dz_r) begin
            res_lo_s = {DATA_W{1'b1}};
            res_hi_s = raw_a_r;
        end else if (is_div_r) begin
            // Quotient sign follows sa^sb; remainder takes the dividend's sign.
            res_lo_s = cond_negate(step_lo_s, is_signed_r && (sa_r ^ sb_r));
            res_hi_s = cond_negate(step_hi_s[DATA_W-1:0], is_signed_r && sa_r);
        end else begin
            res_lo_s = prod_s[DATA_W-1:0];
            res_hi_s = prod_s[2*DATA_W-1:DATA_W];
        end
    end

    // State, iteration counter and working registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            is_div_r    <= 1'b0;
            is_signed_r <= 1'b0;
            sa_r        <= 1'b0;
            sb_r        <= 1'b0;
            dz_r        <= 1'b0;
            raw_a_r     <= {DATA_W{1'b0}};
            m_r         <= {DATA_W{1'b0}};
            work_hi_r   <= {(DATA_W+1){1'b0}};
            work_lo_r   <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (start_s) begin
                cnt_r       <= {CNT_W{1'b0}};
                is_div_r    <= kind_s.is_div;
                is_signed_r <= kind_s.is_signed;
                sa_r        <= a_neg_s;
                sb_r        <= b_neg_s;
                dz_r        <= kind_s.is_div && (src_b == {DATA_W{1'b0}});
                raw_a_r     <= src_a;
                work_hi_r   <= {(DATA_W+1){1'b0}};
                // Multiply shifts the multiplier out of lo; divide shifts the dividend out of lo.
                work_lo_r   <= kind_s.is_div ? abs_a_s : abs_b_s;
                m_r         <= kind_s.is_div ? abs_b_s : abs_a_s;
            end else if (state_r == ST_CALC) begin
                cnt_r     <= cnt_r + CNT_ONE;
                work_hi_r <= step_hi_s;
                work_lo_r <= step_lo_s;
            end else begin
                cnt_r     <= cnt_r;
                work_hi_r <= work_hi_r;
                work_lo_r <= work_lo_r;
            end
        end
    end

    // Result registers: loaded only when an uninterrupted operation completes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_r     <= {DATA_W{1'b0}};
            lo_r     <= {DATA_W{1'b0}};
            done_r   <= 1'b0;
            dz_out_r <= 1'b0;
        end else begin
            done_r   <= finish_s;
            dz_out_r <= finish_s && is_div_r && dz_r;
            if (finish_s) begin
                hi_r <= res_hi_s;
                lo_r <= res_lo_s;
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end
    end

    assign ready       = (state_r == ST_IDLE);
    assign stall       = ((state_r == ST_IDLE) && op_valid && is_md_s) || (state_r == ST_CALC);
    assign done        = done_r;
    assign hi          = hi_r;
    assign lo          = lo_r;
    assign div_by_zero = dz_out_r;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed scoreboard bench for muldiv_iter_unit at DATA_W=32 and DATA_W=16.
module tb_muldiv_iter_unit;
    import muldiv_iter_unit_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [4:0]  alu_control = ALU_ADD;
    logic        op_valid32 = 1'b0;
    logic        op_valid16 = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] src_a = 32'h0;
    logic [31:0] src_b = 32'h0;
    logic        cur16 = 1'b0;

    logic        ready32, stall32, done32, dz32;
    logic [31:0] hi32, lo32;
    logic        ready16, stall16, done16, dz16;
    logic [15:0] hi16, lo16;

    logic        o_ready, o_stall, o_done, o_dz;
    logic [31:0] o_hi, o_lo;

    exp_t sb_q[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muldiv_iter_unit #(.DATA_W(32)) dut32 (
        .clk(clk), .resetn(resetn), .alu_control(alu_control), .op_valid(op_valid32),
        .src_a(src_a), .src_b(src_b), .flush(flush), .ready(ready32), .stall(stall32),
        .done(done32), .hi(hi32), .lo(lo32), .div_by_zero(dz32)
    );

    muldiv_iter_unit #(.DATA_W(16)) dut16 (
        .clk(clk), .resetn(resetn), .alu_control(alu_control), .op_valid(op_valid16),
        .src_a(src_a[15:0]), .src_b(src_b[15:0]), .flush(flush), .ready(ready16), .stall(stall16),
        .done(done16), .hi(hi16), .lo(lo16), .div_by_zero(dz16)
    );

    assign o_ready = cur16 ? ready16 : ready32;
    assign o_stall = cur16 ? stall16 : stall32;
    assign o_done  = cur16 ? done16  : done32;
    assign o_dz    = cur16 ? dz16    : dz32;
    assign o_hi    = cur16 ? {16'h0, hi16} : hi32;
    assign o_lo    = cur16 ? {16'h0, lo16} : lo32;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input int w, input logic [4:0] code,
                                   input logic [31:0] a_in, input logic [31:0] b_in);
        exp_t        r;
        logic [31:0] mask, a, b;
        logic [63:0] p, q, rm;
        longint      sa_v, sb_v;
        mask = (w == 16) ? 32'h0000FFFF : 32'hFFFFFFFF;
        a    = a_in & mask;
        b    = b_in & mask;
        sa_v = (w == 16) ? longint'($signed(a[15:0])) : longint'($signed(a));
        sb_v = (w == 16) ? longint'($signed(b[15:0])) : longint'($signed(b));
        r.dz = 1'b0;
        r.hi = 32'h0;
        r.lo = 32'h0;
        if (code == ALU_UNSIGNED_MULT || code == ALU_SIGNED_MULT) begin
            if (code == ALU_UNSIGNED_MULT) p = {32'h0, a} * {32'h0, b};
            else                           p = sa_v * sb_v;
            r.lo = 32'(p) & mask;
            r.hi = 32'(p >> w) & mask;
        end else if (b == 32'h0) begin
            r.dz = 1'b1;
            r.lo = mask;
            r.hi = a;
        end else if (code == ALU_UNSIGNED_DIV) begin
            r.lo = a / b;
            r.hi = a % b;
        end else begin
            q    = sa_v / sb_v;
            rm   = sa_v % sb_v;
            r.lo = 32'(q) & mask;
            r.hi = 32'(rm) & mask;
        end
        return r;
    endfunction

    task automatic drive_op(input bit is16, input logic [4:0] code,
                            input logic [31:0] a, input logic [31:0] b, input bit push);
        @(negedge clk);
        cur16       = is16;
        alu_control = code;
        src_a       = a;
        src_b       = b;
        op_valid32  = !is16;
        op_valid16  = is16;
        #1;
        check("start_stall", {63'h0, o_stall}, 64'd1);
        check("start_ready", {63'h0, o_ready}, 64'd1);
        if (push) sb_q.push_back(model(is16 ? 16 : 32, code, a, b));
        @(posedge clk);
        #1;
        op_valid32  = 1'b0;
        op_valid16  = 1'b0;
        src_a       = 32'hDEADBEEF;
        src_b       = 32'h00000000;
        alu_control = ALU_SIGNED_DIV;
    endtask

    task automatic wait_result(input bit is16);
        int   w;
        int   lat;
        int   calc_bad;
        exp_t e;
        w        = is16 ? 16 : 32;
        lat      = 0;
        calc_bad = 0;
        e        = sb_q.pop_front();
        for (int k = 1; k <= w + 8; k++) begin
            @(negedge clk);
            if (o_done === 1'b1) begin
                lat = k;
                break;
            end
            if (o_stall !== 1'b1 || o_ready !== 1'b0) calc_bad++;
        end
        check("latency", 64'(lat), 64'(w + 1));
        check("calc_stall_ready", 64'(calc_bad), 64'd0);
        check("done_stall", {63'h0, o_stall}, 64'd0);
        check("hi", {32'h0, o_hi}, {32'h0, e.hi});
        check("lo", {32'h0, o_lo}, {32'h0, e.lo});
        check("div_by_zero", {63'h0, o_dz}, {63'h0, e.dz});
        last_exp = e;
        @(negedge clk);
        check("done_single", {63'h0, o_done}, 64'd0);
        check("ready_after", {63'h0, o_ready}, 64'd1);
        check("hi_hold", {32'h0, o_hi}, {32'h0, e.hi});
    endtask

    task automatic run_op(input bit is16, input logic [4:0] code,
                          input logic [31:0] a, input logic [31:0] b);
        drive_op(is16, code, a, b, 1'b1);
        wait_result(is16);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {63'h0, o_ready}, 64'd1);
        check({tag, "_stall"}, {63'h0, o_stall}, 64'd0);
        check({tag, "_done"},  {63'h0, o_done},  64'd0);
        check({tag, "_dz"},    {63'h0, o_dz},    64'd0);
        check({tag, "_hi"},    {32'h0, o_hi},    64'd0);
        check({tag, "_lo"},    {32'h0, o_lo},    64'd0);
    endtask

    initial begin
        int dones;
        last_exp = '{hi: 32'h0, lo: 32'h0, dz: 1'b0};
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;

        // Non-mul/div code is ignored.
        @(negedge clk);
        alu_control = ALU_ADD;
        src_a       = 32'd5;
        src_b       = 32'd6;
        op_valid32  = 1'b1;
        #1;
        check("nonmd_stall", {63'h0, o_stall}, 64'd0);
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (o_ready !== 1'b1 || o_done !== 1'b0) dones++;
        end
        check("nonmd_idle", 64'(dones), 64'd0);
        op_valid32 = 1'b0;

        run_op(1'b0, ALU_UNSIGNED_MULT, 32'hFFFFFFFF, 32'h00000002);
        run_op(1'b0, ALU_SIGNED_MULT,   32'hFFFFFFFD, 32'd7);
        run_op(1'b0, ALU_SIGNED_DIV,    32'hFFFFFFF9, 32'd2);
        run_op(1'b0, ALU_UNSIGNED_DIV,  32'd100,      32'd7);
        run_op(1'b0, ALU_UNSIGNED_DIV,  32'h12345678, 32'h0);
        run_op(1'b0, ALU_SIGNED_DIV,    32'h80000000, 32'hFFFFFFFF);
        run_op(1'b0, ALU_SIGNED_DIV,    32'd7,        32'hFFFFFFFE);
        run_op(1'b0, ALU_SIGNED_MULT,   32'h80000000, 32'h80000000);

        // Flush during CALC: no done, results untouched, next op completes.
        drive_op(1'b0, ALU_UNSIGNED_MULT, 32'h00001234, 32'h00000010, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_ready", {63'h0, o_ready}, 64'd1);
        check("flush_stall", {63'h0, o_stall}, 64'd0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            if (o_done === 1'b1) dones++;
            @(negedge clk);
        end
        check("flush_no_done", 64'(dones), 64'd0);
        check("flush_hi", {32'h0, o_hi}, {32'h0, last_exp.hi});
        check("flush_lo", {32'h0, o_lo}, {32'h0, last_exp.lo});
        run_op(1'b0, ALU_UNSIGNED_DIV, 32'd1000, 32'd33);

        // Asynchronous reset mid-operation.
        drive_op(1'b0, ALU_SIGNED_MULT, 32'h00000123, 32'hFFFFFF00, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        resetn = 1'b1;
        run_op(1'b0, ALU_SIGNED_MULT, 32'h00000123, 32'hFFFFFF00);

        // Narrow instance.
        run_op(1'b1, ALU_UNSIGNED_MULT, 32'h0000FFFF, 32'h00000002);
        run_op(1'b1, ALU_SIGNED_MULT,   32'h0000FFFD, 32'd7);
        run_op(1'b1, ALU_SIGNED_DIV,    32'h0000FFF9, 32'd2);
        run_op(1'b1, ALU_UNSIGNED_DIV,  32'd100,      32'd7);
        run_op(1'b1, ALU_UNSIGNED_DIV,  32'h00005678, 32'h0);
        run_op(1'b1, ALU_SIGNED_DIV,    32'h00008000, 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
- Parametrised iterative multiply/divide engine in the EX stage.
- Consumes the 5-bit alu_control produced by ALU decode and executes ALU_SIGNED_MULT, ALU_UNSIGNED_MULT, ALU_SIGNED_DIV and ALU_UNSIGNED_DIV over multiple cycles.
- Asserts a stall request while busy, then delivers {hi, lo} for the HI/LO register write.
- Generalises the fixed 32-bit single-op path to DATA_W operands, with abort (flush) support.

Parameters:
- DATA_W, 32, operand width in bits; must be even and at least 4.
- CNT_W, $clog2(DATA_W)+1, iteration counter width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- alu_control  in  5  operation code from the ALU decoder (aludefines.vh encodings)
- op_valid  in  1  operands and alu_control are valid this cycle
- src_a  in  DATA_W  dividend / multiplicand (rs)
- src_b  in  DATA_W  divisor / multiplier (rt)
- flush  in  1  exception/flush from the pipeline; aborts the operation in flight
- ready  out  1  unit idle and able to accept a start
- stall  out  1  pipeline stall request
- done  out  1  single-cycle pulse: result valid
- hi  out  DATA_W  product upper half / remainder
- lo  out  DATA_W  product lower half / quotient
- div_by_zero  out  1  qualifies done: divide op with src_b == 0

Behaviour:
- Reset (resetn low, asynchronous):
  - state = IDLE; ready = 1; stall = 0; done = 0; div_by_zero = 0.
  - hi = 0; lo = 0; counter = 0.
- is_md: alu_control equals one of the four mul/div codes. Any other code is ignored; the unit stays IDLE.
- FSM states: IDLE, CALC, DONE.
  - IDLE -> CALC when op_valid && is_md && !flush. Latch the operation kind (mul/div, signed/unsigned) and the operands.
    - Signed ops: latch |src_a| and |src_b|, plus sign bits sa and sb.
    - Unsigned ops: latch operands as-is.
    - counter = 0.
  - CALC: one iteration per cycle, counter += 1. When counter == DATA_W-1 the iteration completes and the next state is DONE.
  - DONE: apply sign correction, register hi and lo, and assert done for exactly one cycle. Next state is IDLE.
  - flush in any state: go to IDLE next cycle; done is not asserted. hi and lo keep their previous values.
- stall = op_valid && is_md in IDLE (combinational, same-cycle), or state == CALC. stall is 0 in DONE, so the EX instruction advances with done.
- ready = (state == IDLE). A start is not accepted in the DONE cycle.
- Latency: start accepted at edge 0, then DATA_W CALC cycles; done is high in the cycle after the last CALC edge, i.e. DATA_W+1 cycles after the start edge.
- Multiply: shift-add over unsigned magnitudes into a 2*DATA_W accumulator.
  - Signed and sa^sb: result is the two's-complement negation of the 2*DATA_W product.
  - hi = upper DATA_W bits; lo = lower DATA_W bits.
- Divide: restoring, one quotient bit per cycle, remainder DATA_W+1 bits wide internally.
  - Signed: quotient negated if sa^sb; remainder negated if sa (remainder takes the dividend's sign).
  - lo = quotient; hi = remainder.
- Divide by zero: full latency still applies. Result is lo = all ones, hi = src_a (raw, unsigned-interpreted), div_by_zero = 1 with done.
- Signed overflow (most-negative / -1): lo = most-negative, hi = 0. This falls out of the magnitude arithmetic and needs no special-casing.
- hi and lo change only in the DONE cycle and are held stable until the next DONE.
- Inputs are sampled only at start; changes to src_a, src_b or alu_control during CALC have no effect.

Decomposition:
- Shared header: aludefines.vh supplies the mul/div alu_control codes. Add the FSM state encodings (2-bit localparams MD_IDLE, MD_CALC, MD_DONE) there so the hazard unit can reference them.
- One natural sub-module: muldiv_step, a combinational single-iteration datapath selecting between the shift-add and restoring-subtract steps. The FSM, counter and sign handling stay in the top.

Test Plan:
- ALU_UNSIGNED_MULT, a=0xFFFFFFFF, b=0x00000002 -> done at cycle 33; hi=0x00000001, lo=0xFFFFFFFE; stall high cycles 0..32.
- ALU_SIGNED_MULT, a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- ALU_SIGNED_DIV, a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). ALU_UNSIGNED_DIV, a=100, b=7 -> lo=14, hi=2.
- Divide by zero, ALU_UNSIGNED_DIV, a=0x12345678, b=0 -> done at cycle 33 with div_by_zero=1, lo=0xFFFFFFFF, hi=0x12345678.
- Abort cases:
  - flush at CALC cycle 10 -> IDLE next cycle, no done pulse, hi/lo unchanged; a new op in the following cycle completes normally.
  - resetn low at CALC cycle 5 (asynchronous) -> all outputs return to reset values immediately.
- Non-md alu_control (ALU_ADD) with op_valid -> ready stays 1, stall stays 0, no state change. Re-run all cases with DATA_W=16 and check done arrives at cycle 17.
